mem_arbiter: RTL

Single-port memory arbiter between instruction fetch (IF) and the execute stage's data accesses (EX loads/stores). It sits between the core pipeline and the one shared memory bus, serialises the two requesters, and drives per-requester stall signals to the CPU control block. EX has fixed priority, with a starvation guard for IF. A jump flush discards an in-flight fetch response.

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter_starve_cnt.sv | 31 +++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the IF/EX single-port memory arbiter:
//   - DATA_W / data_t : width and type of the address and data buses
//   - arb_state_t     : arbiter FSM state encoding (ARB_IDLE, ARB_BUSY_IF,
//                       ARB_BUSY_EX) and its bus width STATE_W
//   - CNT_W / CNT_MAX : starvation counter width and its saturation value
//   - sat_inc()       : saturating increment used by the starvation counter
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int DATA_W  = 32;
    localparam int STATE_W = 2;
    localparam int CNT_W   = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam cnt_t CNT_MAX = '1;

    typedef enum logic [STATE_W-1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_EX = 2'd2
    } arb_state_t;

    // Increment that sticks at the top value instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t value);
        return (value == CNT_MAX) ? value : value + cnt_t'(1);
    endfunction

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// -----------------------------------------------------------------------------
// arb_starve_cnt
// Saturating counter of consecutive EX grants taken while IF was waiting.
// Ports:
//   clk   in  core clock
//   rst   in  asynchronous active-low reset
//   inc   in  count one more EX grant (ignored when clr is set)
//   clr   in  return to zero (takes priority over inc)
//   count out current value, saturates at CNT_MAX
// -----------------------------------------------------------------------------
module arb_starve_cnt
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output cnt_t count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Serialises instruction fetch (IF) and execute-stage data accesses (EX) onto
// one shared memory bus. EX has fixed priority; after MAX_EX_RUN consecutive
// EX grants with IF waiting, IF is forced through. A flush discards the
// response of an in-flight fetch (the bus transaction itself completes).
// Ports:
//   clk, rst                       core clock, async active-low reset
//   if_req/if_addr -> if_gnt       fetch request, combinational grant
//   if_rvalid/if_rdata             fetch response pulse and data
//   ex_req/ex_we/ex_addr/ex_wdata  data request (load or store)
//   ex_gnt                         combinational data grant
//   ex_rvalid/ex_rdata             load data / store done (data 0 for stores)
//   flush                          jump taken, kill pending fetch
//   bus_req/bus_we/bus_addr/bus_wdata  memory request, held until bus_ready
//   bus_ready/bus_rdata            memory completion and read data
//   stall_if/stall_ex              requester not yet served
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_EX_RUN = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  if_req,
    input  data_t if_addr,
    output logic  if_gnt,
    output logic  if_rvalid,
    output data_t if_rdata,
    input  logic  ex_req,
    input  logic  ex_we,
    input  data_t ex_addr,
    input  data_t ex_wdata,
    output logic  ex_gnt,
    output logic  ex_rvalid,
    output data_t ex_rdata,
    input  logic  flush,
    output logic  bus_req,
    output logic  bus_we,
    output data_t bus_addr,
    output data_t bus_wdata,
    input  logic  bus_ready,
    input  data_t bus_rdata,
    output logic  stall_if,
    output logic  stall_ex
);

    localparam cnt_t MAX_RUN = cnt_t'(MAX_EX_RUN);

    arb_state_t state, state_next;
    logic       grant_if, grant_ex;
    logic       drop;
    cnt_t       starve_cnt;

    arb_starve_cnt u_starve_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (grant_ex & if_req),
        .clr   (grant_if | ~if_req),
        .count (starve_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grants are gated with rst so that every output reads 0 while reset is
    // held, even if a requester keeps its request asserted.
    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_ex   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (rst) begin
                    if (ex_req && (starve_cnt < MAX_RUN || !if_req)) begin
                        grant_ex   = 1'b1;
                        state_next = ARB_BUSY_EX;
                    end else if (if_req && !flush) begin
                        grant_if   = 1'b1;
                        state_next = ARB_BUSY_IF;
                    end
                end
            end
            ARB_BUSY_IF: if (bus_ready) state_next = ARB_IDLE;
            ARB_BUSY_EX: if (bus_ready) state_next = ARB_IDLE;
            default:     state_next = ARB_IDLE;
        endcase
    end

    assign if_gnt   = grant_if;
    assign ex_gnt   = grant_ex;
    assign stall_if = rst & ((if_req & ~grant_if) | ((state == ARB_BUSY_IF) & ~drop));
    assign stall_ex = rst & ((ex_req & ~grant_ex) | (state == ARB_BUSY_EX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            drop      <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            ex_rvalid <= 1'b0;
            ex_rdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            ex_rvalid <= 1'b0;

            if (grant_if) begin
                bus_req   <= 1'b1;
                bus_we    <= 1'b0;
                bus_addr  <= if_addr;
                bus_wdata <= '0;
            end else if (grant_ex) begin
                bus_req   <= 1'b1;
                bus_we    <= ex_we;
                bus_addr  <= ex_addr;
                bus_wdata <= ex_wdata;
            end else if (state != ARB_IDLE && bus_ready) begin
                bus_req <= 1'b0;
            end

            case (state)
                ARB_BUSY_IF: begin
                    if (bus_ready) begin
                        // A flush arriving on the completion cycle also kills the response.
                        drop <= 1'b0;
                        if (!(drop || flush)) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= bus_rdata;
                        end
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                ARB_BUSY_EX: begin
                    if (bus_ready) begin
                        ex_rvalid <= 1'b1;
                        ex_rdata  <= bus_we ? '0 : bus_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
